// File: rtl/mem_latency_interface.sv
// Word-organised simulation memory behind a valid/ready request port with a
// programmable response latency, relocatable base and sub-word extension.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`define MEM_CODE_INVALID       3'd0
`define MEM_CODE_READ          3'd1
`define MEM_CODE_WRITE         3'd2
`define MEM_CODE_MISALIGNED    3'd3
`define MEM_CODE_OUT_OF_BOUNDS 3'd4
`endif

module mem_latency_interface #(
   parameter int unsigned        WORD_COUNT = 1024,
   parameter logic [`ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int unsigned        LATENCY    = 1
) (
   input  logic                    clk,
   input  logic                    aresetn,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic [`ADDR_W-1:0]      i_req_addr,
   input  logic [`WORD_W-1:0]      i_req_wr_data,
   input  logic                    i_req_wr_en,
   input  logic [`MEM_COUNT_W-1:0] i_req_count,
   input  logic                    i_req_unsigned,
   output logic                    o_res_valid,
   output logic [`WORD_W-1:0]      o_res_rd_data,
   output logic [`MEM_CODE_W-1:0]  o_res_code
);

   localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_e;

   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [`WORD_W-1:0]       rd_q;
   logic [`MEM_CODE_W-1:0]   code_q;
   logic [`WORD_W-1:0]       mem_q [WORD_COUNT];

   logic                     accept_c;
   logic [`ADDR_W-1:0]       offset_c;
   logic                     in_range_c;
   logic                     misaligned_c;
   logic [IDX_W-1:0]         idx_c;
   logic [`WORD_W-1:0]       rd_word_c;
   logic [15:0]              lane_c;
   logic [3:0]               wr_be_c;
   logic [`WORD_W-1:0]       wr_word_c;
   logic [`WORD_W-1:0]       rd_d;
   logic [`MEM_CODE_W-1:0]   code_d;

   assign o_req_ready   = (state_q != ST_WAIT);
   assign o_res_valid   = (state_q == ST_RESP);
   assign o_res_rd_data = o_res_valid ? rd_q : '0;
   assign o_res_code    = o_res_valid ? code_q : `MEM_CODE_INVALID;

   assign accept_c     = i_req_valid && o_req_ready;
   // Below-base test guards the subtraction so a wrapped offset never aliases in range
   assign offset_c     = i_req_addr - BASE_ADDR;
   assign in_range_c   = (i_req_addr >= BASE_ADDR) &&
                         ({2'b00, offset_c[`ADDR_W-1:2]} < `ADDR_W'(WORD_COUNT));
   assign misaligned_c = ((i_req_count == `MEM_COUNT_HALF) && i_req_addr[0]) ||
                         ((i_req_count == `MEM_COUNT_WORD) && (i_req_addr[1:0] != 2'b00));
   assign idx_c        = offset_c[IDX_W+1:2];
   assign rd_word_c    = mem_q[idx_c];
   assign lane_c       = 16'(rd_word_c >> {i_req_addr[1:0], 3'b000});

   // Request classification, write lane enables and extended read data
   always_comb begin
      code_d    = `MEM_CODE_INVALID;
      rd_d      = '0;
      wr_be_c   = '0;
      wr_word_c = i_req_wr_data;
      if (i_req_count == `MEM_COUNT_NONE) begin
         code_d = `MEM_CODE_INVALID;
      end else if (misaligned_c) begin
         code_d = `MEM_CODE_MISALIGNED;
      end else if (!in_range_c) begin
         code_d = `MEM_CODE_OUT_OF_BOUNDS;
      end else if (i_req_wr_en) begin
         code_d = `MEM_CODE_WRITE;
         case (i_req_count)
            `MEM_COUNT_BYTE: begin
               wr_be_c   = 4'b0001 << i_req_addr[1:0];
               wr_word_c = {4{i_req_wr_data[7:0]}};
            end
            `MEM_COUNT_HALF: begin
               wr_be_c   = i_req_addr[1] ? 4'b1100 : 4'b0011;
               wr_word_c = {2{i_req_wr_data[15:0]}};
            end
            default: wr_be_c = 4'b1111;
         endcase
      end else begin
         code_d = `MEM_CODE_READ;
         case (i_req_count)
            `MEM_COUNT_BYTE: rd_d = {{24{~i_req_unsigned & lane_c[7]}}, lane_c[7:0]};
            `MEM_COUNT_HALF: rd_d = {{16{~i_req_unsigned & lane_c[15]}}, lane_c[15:0]};
            default:         rd_d = rd_word_c;
         endcase
      end
   end

   // Request/response sequencing: one request outstanding, fixed latency
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         code_q  <= `MEM_CODE_INVALID;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               if (accept_c) begin
                  rd_q   <= rd_d;
                  code_q <= code_d;
                  if (LATENCY == 1) begin
                     state_q <= ST_RESP;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_W'(LATENCY - 2);
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Memory array: cleared by reset, byte-lane writes on accept
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int w = 0; w < int'(WORD_COUNT); w++) begin
            mem_q[w] <= '0;
         end
      end else if (accept_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be_c[b]) begin
               mem_q[idx_c][8*b +: 8] <= wr_word_c[8*b +: 8];
            end
         end
      end
   end

endmodule
